// File: rtl/channel_capture_pkg.sv
// Shared types and default widths for the 64-channel logic-capture reader.
package channel_capture_pkg;

  localparam int unsigned CH_W_DFLT       = 64;
  localparam int unsigned DUR_W_DFLT      = 32;
  localparam int unsigned FIFO_DEPTH_DFLT = 16;
  localparam int unsigned REC_W           = DUR_W_DFLT + CH_W_DFLT + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  typedef struct packed {
    logic                  tlast;
    logic [DUR_W_DFLT-1:0] dur;
    logic [CH_W_DFLT-1:0]  val;
  } record_t;

  // Record width for a given channel/duration width pair.
  function automatic int unsigned rec_width(input int unsigned ch_w, input int unsigned dur_w);
    return dur_w + ch_w + 1;
  endfunction

endpackage

// File: rtl/capture_fifo.sv
// Synchronous first-word-fall-through record FIFO with synchronous clear.
module capture_fifo #(
  parameter int unsigned WIDTH = 97,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] pop_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty & ~clear;
  assign do_push = push & ~clear & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Head is forced to zero while empty so the stream bus idles at zero.
  assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/channel_capture.sv
// Triggered 64-channel logic capture, run-length encoded into {duration, value} records.
module channel_capture
  import channel_capture_pkg::*;
#(
  parameter int unsigned CH_W       = CH_W_DFLT,
  parameter int unsigned DUR_W      = DUR_W_DFLT,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DFLT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  stop,
  input  logic                  abort,
  input  logic                  trigger,
  input  logic [CH_W-1:0]       channels,
  output logic [DUR_W+CH_W-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  running,
  output logic                  overflow
);

  localparam int unsigned RW = rec_width(CH_W, DUR_W);
  localparam logic [DUR_W-1:0] DUR_MAX = '1;

  typedef struct packed {
    logic             tlast;
    logic [DUR_W-1:0] dur;
    logic [CH_W-1:0]  val;
  } rec_t;

  logic            trig_s1, trig_s2, trig_d;
  logic [CH_W-1:0] ch_s1, ch_s2;
  logic            trig_edge;

  state_t           state, state_n;
  logic [CH_W-1:0]  cur_val, cur_val_n;
  logic [DUR_W-1:0] dur, dur_n;
  logic             push, push_last, ovf_set, ovf_clr, fifo_clear;
  logic             fifo_full, fifo_empty, pop, room;
  rec_t             push_rec, pop_rec;

  // Two-flop synchronizers plus a delayed trigger copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_s1 <= 1'b0;
      trig_s2 <= 1'b0;
      trig_d  <= 1'b0;
      ch_s1   <= '0;
      ch_s2   <= '0;
    end else begin
      trig_s1 <= trigger;
      trig_s2 <= trig_s1;
      trig_d  <= trig_s2;
      ch_s1   <= channels;
      ch_s2   <= ch_s1;
    end
  end

  assign trig_edge = trig_s2 & ~trig_d;
  assign pop       = m_tvalid & m_tready;
  assign room      = ~fifo_full | pop;

  always_comb begin
    state_n    = state;
    cur_val_n  = cur_val;
    dur_n      = dur;
    push       = 1'b0;
    push_last  = 1'b0;
    ovf_set    = 1'b0;
    ovf_clr    = 1'b0;
    fifo_clear = 1'b0;
    case (state)
      IDLE: begin
        if (arm) begin
          state_n = ARMED;
          ovf_clr = 1'b1;
        end
      end
      ARMED: begin
        if (abort) begin
          state_n = IDLE;
        end else if (trig_edge) begin
          state_n   = RUN;
          cur_val_n = ch_s2;
          dur_n     = DUR_W'(1);
        end
      end
      RUN: begin
        if (abort) begin
          state_n    = IDLE;
          fifo_clear = 1'b1;
        end else if (stop) begin
          state_n = FLUSH;
        end else if (ch_s2 != cur_val) begin
          push      = 1'b1;
          cur_val_n = ch_s2;
          dur_n     = DUR_W'(1);
        end else if (dur == DUR_MAX) begin
          push  = 1'b1;
          dur_n = DUR_W'(1);
        end else begin
          dur_n = dur + DUR_W'(1);
        end
        // A dropped record still advances the encoder as if it were stored.
        ovf_set = push & ~room;
      end
      FLUSH: begin
        if (abort) begin
          state_n    = IDLE;
          fifo_clear = 1'b1;
        end else if (room) begin
          push      = 1'b1;
          push_last = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cur_val  <= '0;
      dur      <= '0;
      overflow <= 1'b0;
      running  <= 1'b0;
    end else begin
      state   <= state_n;
      cur_val <= cur_val_n;
      dur     <= dur_n;
      running <= (state_n == RUN) || (state_n == FLUSH);
      if (ovf_clr)      overflow <= 1'b0;
      else if (ovf_set) overflow <= 1'b1;
    end
  end

  assign push_rec = '{tlast: push_last, dur: dur, val: cur_val};

  capture_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (fifo_clear),
    .push      (push & room),
    .push_data (push_rec),
    .full      (fifo_full),
    .pop       (pop),
    .empty     (fifo_empty),
    .pop_data  (pop_rec)
  );

  assign m_tvalid = ~fifo_empty;
  assign m_tlast  = pop_rec.tlast;
  assign m_tdata  = {pop_rec.dur, pop_rec.val};

endmodule
